// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if
// Bundles the register-file write-port arbitration signals shared by the
// MEM/WB stage, the long-latency execution unit and the register file.
//   pipe_PD/pipe_RD/pipe_LE : writeback data/dest/enable from MEM/WB
//   ll_valid/ll_data/ll_rd  : long-latency result offer
//   ll_ready                : arbiter can accept a long-latency result
//   rf_PD/rf_RD/rf_LE       : register-file write port
//   stall_req               : request to the hazard unit for writeback bubbles
//   buf_count               : number of buffered long-latency results
// Modport slave is the arbiter; modport master is the surrounding pipeline.
interface wb_port_arbiter_if;
    logic [31:0] pipe_PD;
    logic [4:0]  pipe_RD;
    logic        pipe_LE;
    logic        ll_valid;
    logic [31:0] ll_data;
    logic [4:0]  ll_rd;
    logic        ll_ready;
    logic [31:0] rf_PD;
    logic [4:0]  rf_RD;
    logic        rf_LE;
    logic        stall_req;
    logic [1:0]  buf_count;

    modport slave (
        input  pipe_PD, pipe_RD, pipe_LE, ll_valid, ll_data, ll_rd,
        output ll_ready, rf_PD, rf_RD, rf_LE, stall_req, buf_count
    );

    modport master (
        output pipe_PD, pipe_RD, pipe_LE, ll_valid, ll_data, ll_rd,
        input  ll_ready, rf_PD, rf_RD, rf_LE, stall_req, buf_count
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the single register-file write port between the in-order writeback
// stage and an out-of-band long-latency unit. The pipeline always wins; LL
// results wait in a 2-entry compacted buffer (slot 0 = oldest) and drain into
// pipeline bubbles. Pipeline writes cancel stale buffered results to the same
// register, a newer LL result replaces an older buffered one to the same
// register, and a saturating starvation counter raises stall_req when the
// buffer has been blocked for STARVE_LIMIT consecutive cycles.
// Ports:
//   clk    : clock, all state on posedge
//   Reset  : synchronous, active-high reset
//   bus    : wb_port_arbiter_if.slave (pipe_*, ll_*, rf_*, stall_req, buf_count)
module wb_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              Reset,
    wb_port_arbiter_if.slave  bus
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic        v0, v1;
    logic [4:0]  rd0, rd1;
    logic [31:0] d0, d1;
    logic [3:0]  starve_cnt;
    logic        stall_q;

    logic        v0_n, v1_n;
    logic [4:0]  rd0_n, rd1_n;
    logic [31:0] d0_n, d1_n;
    logic [3:0]  starve_cnt_n;

    logic pop, blocked, kill_en, enq_acc, enq_wr, keep0, keep1;

    always_comb begin
        pop     = ~bus.pipe_LE & v0;
        blocked =  bus.pipe_LE & v0;
        kill_en =  bus.pipe_LE & (bus.pipe_RD != 5'd0);
        // ready comes from registered state only (compacted: full == v1)
        enq_acc = bus.ll_valid & ~(v0 & v1);
        // GR0 results complete the handshake but are never buffered
        enq_wr  = enq_acc & (bus.ll_rd != 5'd0);

        // An entry survives unless popped, killed by a younger pipeline
        // write, or superseded by the newly accepted LL result.
        keep0 = v0 & ~pop
                   & ~(kill_en & (rd0 == bus.pipe_RD))
                   & ~(enq_wr  & (rd0 == bus.ll_rd));
        keep1 = v1 & ~(kill_en & (rd1 == bus.pipe_RD))
                   & ~(enq_wr  & (rd1 == bus.ll_rd));

        v0_n  = 1'b0;
        rd0_n = 5'd0;
        d0_n  = 32'd0;
        v1_n  = 1'b0;
        rd1_n = 5'd0;
        d1_n  = 32'd0;

        // Recompact survivors in age order, then append the new entry.
        // keep0 & keep1 implies the buffer was full, so enq_wr is 0 there.
        if (keep0) begin
            v0_n  = 1'b1;
            rd0_n = rd0;
            d0_n  = d0;
            if (keep1) begin
                v1_n  = 1'b1;
                rd1_n = rd1;
                d1_n  = d1;
            end else if (enq_wr) begin
                v1_n  = 1'b1;
                rd1_n = bus.ll_rd;
                d1_n  = bus.ll_data;
            end
        end else if (keep1) begin
            v0_n  = 1'b1;
            rd0_n = rd1;
            d0_n  = d1;
            if (enq_wr) begin
                v1_n  = 1'b1;
                rd1_n = bus.ll_rd;
                d1_n  = bus.ll_data;
            end
        end else if (enq_wr) begin
            v0_n  = 1'b1;
            rd0_n = bus.ll_rd;
            d0_n  = bus.ll_data;
        end

        if (pop || !v0_n) begin
            starve_cnt_n = 4'd0;
        end else if (blocked) begin
            starve_cnt_n = (starve_cnt >= LIMIT) ? LIMIT : starve_cnt + 4'd1;
        end else begin
            starve_cnt_n = starve_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            v0         <= 1'b0;
            v1         <= 1'b0;
            rd0        <= 5'd0;
            rd1        <= 5'd0;
            d0         <= 32'd0;
            d1         <= 32'd0;
            starve_cnt <= 4'd0;
            stall_q    <= 1'b0;
        end else begin
            v0         <= v0_n;
            v1         <= v1_n;
            rd0        <= rd0_n;
            rd1        <= rd1_n;
            d0         <= d0_n;
            d1         <= d1_n;
            starve_cnt <= starve_cnt_n;
            stall_q    <= (starve_cnt_n == LIMIT);
        end
    end

    always_comb begin
        if (bus.pipe_LE) begin
            bus.rf_LE = 1'b1;
            bus.rf_RD = bus.pipe_RD;
            bus.rf_PD = bus.pipe_PD;
        end else if (v0) begin
            bus.rf_LE = 1'b1;
            bus.rf_RD = rd0;
            bus.rf_PD = d0;
        end else begin
            bus.rf_LE = 1'b0;
            bus.rf_RD = 5'd0;
            bus.rf_PD = 32'd0;
        end
    end

    assign bus.ll_ready  = ~(v0 & v1);
    assign bus.stall_req = stall_q;
    assign bus.buf_count = {1'b0, v0} + {1'b0, v1};

endmodule
